root_5_multi_cycle: RTL

ROOT_5_MULTI_CYCLE -- requirements
Module: root_5_multi_cycle

---
 rtl/root_5_multi_cycle_if.sv | 27 ++
 rtl/root_5_multi_cycle.sv | 105 ++++++++++
 2 files changed

// File: rtl/root_5_multi_cycle_if.sv
// Request/result bus of the bit-serial fifth-root block.
// The master drives the argument and the slave returns the result.
interface root_5_multi_cycle_if #(
    parameter int w = 8
);
    logic         arg_vld;
    logic [w-1:0] arg;
    logic         busy;
    logic         res_vld;
    logic [w-1:0] res;

    modport master (
        output arg_vld,
        output arg,
        input  busy,
        input  res_vld,
        input  res
    );

    modport slave (
        input  arg_vld,
        input  arg,
        output busy,
        output res_vld,
        output res
    );
endinterface

// File: rtl/root_5_multi_cycle.sv
// Integer fifth root, floor(x^(1/5)), found by a bit-serial binary search.
// One shared multiplier raises each candidate to the fifth power over four cycles.
//
//  state   | meaning
//  --------+----------------------------------------------------------
//  S_IDLE  | waiting for arg_vld; latches the argument on accept
//  S_SETUP | forms candidate = root | (1 << bit) and loads p with it
//  S_MUL   | p <= p * candidate, four times, which leaves candidate^5 in p
//  S_CMP   | keeps the root bit if candidate^5 <= argument, then next bit
//  S_DONE  | publishes root on res and raises res_vld for the next cycle
module root_5_multi_cycle #(
    parameter int w = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    root_5_multi_cycle_if.slave  bus
);
    localparam int rw = (w + 4) / 5;
    localparam int pw = 5 * rw;
    localparam int bw = (rw > 1) ? $clog2(rw) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_MUL,
        S_CMP,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [w-1:0]    arg_q;
    logic [rw-1:0]   root_q;
    logic [bw-1:0]   bit_q;
    logic [1:0]      cnt_q;
    logic [pw-1:0]   p_q;
    logic [w-1:0]    res_q;
    logic            res_vld_q;

    logic [rw-1:0]   cand_d;
    logic [pw-1:0]   prod_d;
    logic [pw-1:0]   arg_ext_d;

    // Candidate stays below 2^rw, so its fifth power always fits in pw bits.
    assign cand_d    = root_q | (rw'(1) << bit_q);
    assign prod_d    = p_q * pw'(cand_d);
    assign arg_ext_d = pw'(arg_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            root_q    <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            res_vld_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.arg_vld) begin
                        arg_q   <= bus.arg;
                        root_q  <= '0;
                        bit_q   <= bw'(rw - 1);
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    p_q     <= pw'(cand_d);
                    cnt_q   <= '0;
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    p_q   <= prod_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (p_q <= arg_ext_d) begin
                        root_q[bit_q] <= 1'b1;
                    end
                    if (bit_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        bit_q   <= bit_q - bw'(1);
                        state_q <= S_SETUP;
                    end
                end
                S_DONE: begin
                    res_q     <= w'(root_q);
                    res_vld_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.res_vld = res_vld_q;
    assign bus.res     = res_q;
endmodule
